// File: rtl/fsm_io_pkg.sv
// rtl/fsm_io_pkg.sv - shared types and constants for the step-input conditioning stage
package fsm_io_pkg;

  typedef enum logic [1:0] {IDLE, STEP, ERR, WAIT_REL} step_state_t;

  localparam int   SW_W        = 4;
  localparam logic KEY_PRESSED = 1'b0;

  function automatic logic [2:0] sw_popcount(input logic [SW_W-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < SW_W; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - level debouncer for the synchronised step button
module btn_debounce
  import fsm_io_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_s,
  output logic press_rise,
  output logic rel
);

  localparam int             CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (key_s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = key_s;
      cnt_d   = '0;
      rise_d  = (key_s == KEY_PRESSED);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Level starts PRESSED so a button held through reset never looks like a fresh press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      level_q <= KEY_PRESSED;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign press_rise = rise_q;
  assign rel        = (level_q != KEY_PRESSED);

endmodule

// File: rtl/switch_step_ctrl.sv
// rtl/switch_step_ctrl.sv - synchronises button/switches and issues validated single-cycle steps
module switch_step_ctrl
  import fsm_io_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_n,
  input  logic [SW_W-1:0]  sw_raw,
  output logic             step,
  output logic [SW_W-1:0]  sw_q,
  output logic             err_multi,
  output logic             busy,
  output logic [CNT_W-1:0] step_cnt
);

  logic [SYNC_STAGES-1:0] key_sync_q;
  logic [SW_W-1:0]        sw_sync_q [SYNC_STAGES];
  logic                   key_s;
  logic [SW_W-1:0]        sw_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_sync_q <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync_q[i] <= '0;
      end
    end else begin
      key_sync_q <= {key_sync_q[SYNC_STAGES-2:0], key_n};
      sw_sync_q[0] <= sw_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync_q[i] <= sw_sync_q[i-1];
      end
    end
  end

  assign key_s = key_sync_q[SYNC_STAGES-1];
  assign sw_s  = sw_sync_q[SYNC_STAGES-1];

  logic press_rise;
  logic rel;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .key_s      (key_s),
    .press_rise (press_rise),
    .rel        (rel)
  );

  step_state_t      state_q, state_d;
  logic [SW_W-1:0]  sw_hold_q, sw_hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    sw_hold_d = sw_hold_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (press_rise) begin
          if (sw_popcount(sw_s) <= 3'd1) begin
            state_d   = STEP;
            sw_hold_d = sw_s;
            cnt_d     = cnt_q + CNT_W'(1);
          end else begin
            state_d = ERR;
          end
        end
      end
      STEP:     state_d = WAIT_REL;
      ERR:      state_d = WAIT_REL;
      WAIT_REL: if (rel) state_d = IDLE;
      default:  state_d = WAIT_REL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= WAIT_REL;
      sw_hold_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sw_hold_q <= sw_hold_d;
      cnt_q     <= cnt_d;
    end
  end

  // Strobes decode directly from the state register, so they are glitch-free and mutually exclusive.
  assign step      = (state_q == STEP);
  assign err_multi = (state_q == ERR);
  assign busy      = (state_q != IDLE);
  assign sw_q      = sw_hold_q;
  assign step_cnt  = cnt_q;

endmodule
